// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with flush, hold and load-use bubble insertion.
// Optional bubble counter is enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [11:0]     id_ctrl,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [14:0]     id_regs,
  input  logic [3:0]      id_funct4,
  input  logic            ex_ready,
  input  logic            flush,
  output logic            ex_valid,
  output logic [11:0]     ex_ctrl,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [14:0]     ex_regs,
  output logic [3:0]      ex_funct4,
`ifdef ID_EX_PERF_CNT_EN
  output logic [15:0]     bubble_cnt,
`endif
  output logic            stall_id
);

  // Control bundle layout: {alu_src, alu_op[1:0], mem_read, mem_write,
  // reg_write, mem_to_reg, branch, jump, imm_type[2:0]}
  localparam int CTRL_ALU_SRC   = 11;
  localparam int CTRL_MEM_READ  = 8;
  localparam int CTRL_MEM_WRITE = 7;
  localparam logic [2:0] IMM_U  = 3'b011;
  localparam logic [2:0] IMM_J  = 3'b100;

  logic            r_valid;
  logic [11:0]     r_ctrl;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_rs1_data;
  logic [XLEN-1:0] r_rs2_data;
  logic [XLEN-1:0] r_imm;
  logic [14:0]     r_regs;
  logic [3:0]      r_funct4;

  logic [4:0] w_ex_rd;
  logic [4:0] w_id_rs1;
  logic [4:0] w_id_rs2;
  logic       w_uses_rs1;
  logic       w_uses_rs2;
  logic       w_load_use;
  logic       w_hold;
  logic       w_bubble;

  assign w_ex_rd  = r_regs[4:0];
  assign w_id_rs1 = id_regs[14:10];
  assign w_id_rs2 = id_regs[9:5];

  // U- and J-type encodings carry no rs1 operand; rs2 is read only for
  // register-register ALU ops and stores.
  assign w_uses_rs1 = (id_ctrl[2:0] != IMM_U) && (id_ctrl[2:0] != IMM_J);
  assign w_uses_rs2 = !id_ctrl[CTRL_ALU_SRC] || id_ctrl[CTRL_MEM_WRITE];

  assign w_load_use = r_valid && r_ctrl[CTRL_MEM_READ] && (w_ex_rd != 5'd0) &&
                      id_valid &&
                      ((w_uses_rs1 && (w_ex_rd == w_id_rs1)) ||
                       (w_uses_rs2 && (w_ex_rd == w_id_rs2)));

  assign w_hold   = !flush && !ex_ready;
  // A bubble is loaded on flush, or on a load-use hazard when EX is free.
  assign w_bubble = flush || (ex_ready && w_load_use);

  assign stall_id = rst_n && !flush && (!ex_ready || w_load_use);

  always_ff @(posedge clk) begin
    if (!rst_n || w_bubble) begin
      r_valid    <= 1'b0;
      r_ctrl     <= '0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_regs     <= '0;
      r_funct4   <= '0;
    end else if (!w_hold) begin
      r_valid    <= id_valid;
      r_ctrl     <= id_valid ? id_ctrl : 12'd0;
      r_pc       <= id_pc;
      r_rs1_data <= id_rs1_data;
      r_rs2_data <= id_rs2_data;
      r_imm      <= id_imm;
      r_regs     <= id_regs;
      r_funct4   <= id_funct4;
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  logic [15:0] r_bubble_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bubble_cnt <= '0;
    end else if (w_bubble && (r_bubble_cnt != 16'hFFFF)) begin
      r_bubble_cnt <= r_bubble_cnt + 16'd1;
    end
  end

  assign bubble_cnt = r_bubble_cnt;
`endif

  assign ex_valid    = r_valid;
  assign ex_ctrl     = r_ctrl;
  assign ex_pc       = r_pc;
  assign ex_rs1_data = r_rs1_data;
  assign ex_rs2_data = r_rs2_data;
  assign ex_imm      = r_imm;
  assign ex_regs     = r_regs;
  assign ex_funct4   = r_funct4;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: spec-level model compared every cycle
// plus hand-computed literal expectations. Honors ID_EX_PERF_CNT_EN.
module tb_id_ex_stage;

  localparam int XLEN = 32;

  // Hand-encoded control words
  localparam logic [11:0] C_ADD = 12'h447;  // R-type add
  localparam logic [11:0] C_LW  = 12'h960;  // load word, I-type
  localparam logic [11:0] C_LUI = 12'h843;  // U-type
  localparam logic [11:0] C_SW  = 12'h881;  // store: alu_src=1, mem_write=1, S-type

  logic            clk;
  logic            rst_n;
  logic            id_valid;
  logic [11:0]     id_ctrl;
  logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [14:0]     id_regs;
  logic [3:0]      id_funct4;
  logic            ex_ready;
  logic            flush;
  logic            ex_valid;
  logic [11:0]     ex_ctrl;
  logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [14:0]     ex_regs;
  logic [3:0]      ex_funct4;
  logic            stall_id;
`ifdef ID_EX_PERF_CNT_EN
  logic [15:0]     bubble_cnt;
`endif

  id_ex_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_ctrl(id_ctrl), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_regs(id_regs), .id_funct4(id_funct4),
    .ex_ready(ex_ready), .flush(flush),
    .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_pc(ex_pc),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_regs(ex_regs), .ex_funct4(ex_funct4),
`ifdef ID_EX_PERF_CNT_EN
    .bubble_cnt(bubble_cnt),
`endif
    .stall_id(stall_id)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic check_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic            valid;
    logic [11:0]     ctrl;
    logic [XLEN-1:0] pc, rs1d, rs2d, imm;
    logic [14:0]     regs;
    logic [3:0]      f4;
  } ex_t;

  ex_t         m_ex;
  int unsigned m_cnt;

  function automatic bit model_load_use(ex_t e);
    bit use1, use2;
    int rd;
    rd   = int'(e.regs[4:0]);
    use1 = !(id_ctrl[2:0] == 3'd3 || id_ctrl[2:0] == 3'd4);
    use2 = (id_ctrl[11] == 1'b0) || (id_ctrl[7] == 1'b1);
    return e.valid && e.ctrl[8] && rd != 0 && id_valid &&
           ((use1 && rd == int'(id_regs[14:10])) || (use2 && rd == int'(id_regs[9:5])));
  endfunction

  function automatic ex_t zero_ex();
    ex_t z;
    z.valid = 0; z.ctrl = 0; z.pc = 0; z.rs1d = 0; z.rs2d = 0;
    z.imm = 0; z.regs = 0; z.f4 = 0;
    return z;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_ex  = zero_ex();
      m_cnt = 0;
    end else if (flush) begin
      m_ex  = zero_ex();
      m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
    end else if (!ex_ready) begin
      m_ex = m_ex;
    end else if (model_load_use(m_ex)) begin
      m_ex  = zero_ex();
      m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
    end else begin
      m_ex.valid = id_valid;
      m_ex.ctrl  = id_valid ? id_ctrl : 12'd0;
      m_ex.pc    = id_pc;
      m_ex.rs1d  = id_rs1_data;
      m_ex.rs2d  = id_rs2_data;
      m_ex.imm   = id_imm;
      m_ex.regs  = id_regs;
      m_ex.f4    = id_funct4;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (check_en) begin
      logic exp_stall;
      exp_stall = rst_n && !flush && (!ex_ready || model_load_use(m_ex));
      chk("stall_id", 32'(stall_id), 32'(exp_stall));
      chk("ex_valid", 32'(ex_valid), 32'(m_ex.valid));
      chk("ex_ctrl",  32'(ex_ctrl),  32'(m_ex.ctrl));
      chk("ex_pc",    ex_pc,         m_ex.pc);
      chk("ex_rs1",   ex_rs1_data,   m_ex.rs1d);
      chk("ex_rs2",   ex_rs2_data,   m_ex.rs2d);
      chk("ex_imm",   ex_imm,        m_ex.imm);
      chk("ex_regs",  32'(ex_regs),  32'(m_ex.regs));
      chk("ex_f4",    32'(ex_funct4), 32'(m_ex.f4));
`ifdef ID_EX_PERF_CNT_EN
      chk("bubble_cnt", 32'(bubble_cnt), m_cnt);
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [11:0] c, input logic [31:0] pc,
                       input logic [14:0] regs, input logic rdy, input logic fl);
    id_valid    = v;
    id_ctrl     = c;
    id_pc       = pc;
    id_rs1_data = pc ^ 32'hA5A5_0000;
    id_rs2_data = pc + 32'd7;
    id_imm      = {pc[15:0], 16'h0};
    id_regs     = regs;
    id_funct4   = pc[5:2];
    ex_ready    = rdy;
    flush       = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [14:0] rg(input int rs1, input int rs2, input int rd);
    return {5'(rs1), 5'(rs2), 5'(rd)};
  endfunction

  // ---------------- directed sequence ----------------
  logic [31:0] held_pc;

  initial begin
    rst_n = 1'b0;
    drive(1'b1, 12'hFFF, 32'hDEAD_BEEF, 15'h7FFF, 1'b1, 1'b0);
    #1;
    chk("lit_stall_in_reset", 32'(stall_id), 32'd0);
    step();
    check_en = 1'b1;
    chk("lit_reset_valid", 32'(ex_valid), 32'd0);
    chk("lit_reset_ctrl",  32'(ex_ctrl),  32'd0);
    chk("lit_reset_pc",    ex_pc,         32'd0);

    // first capture after reset release
    rst_n = 1'b1;
    drive(1'b1, C_ADD, 32'h100, rg(1, 2, 3), 1'b1, 1'b0);
    step();
    chk("lit_cap_pc",    ex_pc,         32'h100);
    chk("lit_cap_ctrl",  32'(ex_ctrl),  32'h447);
    chk("lit_cap_valid", 32'(ex_valid), 32'd1);

    // load-use: lw x5 then add rs2=x5
    drive(1'b1, C_LW, 32'h104, rg(1, 0, 5), 1'b1, 1'b0);
    step();
    drive(1'b1, C_ADD, 32'h108, rg(3, 5, 6), 1'b1, 1'b0);
    #1;
    chk("lit_lu_stall", 32'(stall_id), 32'd1);
    step();
    chk("lit_lu_bubble_ctrl",  32'(ex_ctrl),  32'd0);
    chk("lit_lu_bubble_valid", 32'(ex_valid), 32'd0);
    #1;
    chk("lit_lu_release_stall", 32'(stall_id), 32'd0);
    step();
    chk("lit_lu_add_pc",   ex_pc,        32'h108);
    chk("lit_lu_add_ctrl", 32'(ex_ctrl), 32'h447);

    // lui rd=7 after lw x5: no rs use, so no stall
    drive(1'b1, C_LW, 32'h10C, rg(1, 0, 5), 1'b1, 1'b0);
    step();
    drive(1'b1, C_LUI, 32'h110, rg(5, 5, 7), 1'b1, 1'b0);
    #1;
    chk("lit_lui_stall", 32'(stall_id), 32'd0);
    step();
    chk("lit_lui_ctrl", 32'(ex_ctrl), 32'h843);

    // store after load: rs2 used via mem_write
    drive(1'b1, C_LW, 32'h114, rg(1, 0, 9), 1'b1, 1'b0);
    step();
    drive(1'b1, C_SW, 32'h118, rg(2, 9, 0), 1'b1, 1'b0);
    #1;
    chk("lit_sw_stall", 32'(stall_id), 32'd1);
    step();
    step();

    // lw rd=x0 never stalls
    drive(1'b1, C_LW, 32'h11C, rg(1, 0, 0), 1'b1, 1'b0);
    step();
    drive(1'b1, C_ADD, 32'h120, rg(0, 0, 4), 1'b1, 1'b0);
    #1;
    chk("lit_x0_stall", 32'(stall_id), 32'd0);
    step();
    chk("lit_x0_pc", ex_pc, 32'h120);

    // flush + hold with pending load-use
    drive(1'b1, C_LW, 32'h124, rg(1, 0, 5), 1'b1, 1'b0);
    step();
    drive(1'b1, C_ADD, 32'h128, rg(5, 1, 6), 1'b0, 1'b1);
    #1;
    chk("lit_flush_stall", 32'(stall_id), 32'd0);
    step();
    chk("lit_flush_ctrl", 32'(ex_ctrl), 32'd0);
    chk("lit_flush_pc",   ex_pc,        32'd0);

    // hold: three cycles with changing ID contents
    drive(1'b1, C_ADD, 32'h200, rg(1, 2, 3), 1'b1, 1'b0);
    step();
    held_pc = ex_pc;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, C_LW ^ 12'(i), 32'h300 + 32'(4 * i), rg(i, i + 1, i + 2), 1'b0, 1'b0);
      #1;
      chk("lit_hold_stall", 32'(stall_id), 32'd1);
      step();
      chk("lit_hold_pc", ex_pc, 32'h200);
    end

    // invalid ID instruction loads zero control
    drive(1'b0, 12'hFFF, 32'h400, rg(1, 2, 3), 1'b1, 1'b0);
    step();
    chk("lit_inv_ctrl", 32'(ex_ctrl), 32'd0);

    // reset overrides flush and hold
    drive(1'b1, C_ADD, 32'h500, rg(1, 2, 3), 1'b1, 1'b0);
    step();
    rst_n = 1'b0;
    drive(1'b1, C_ADD, 32'h504, rg(1, 2, 3), 1'b0, 1'b1);
    #1;
    chk("lit_rst_stall", 32'(stall_id), 32'd0);
    step();
    chk("lit_rst_pc", ex_pc, 32'd0);
    rst_n = 1'b1;

    // pseudo-random mix checked by the model
    for (int i = 0; i < 200; i++) begin
      logic [11:0] c;
      case ($urandom_range(0, 4))
        0: c = C_ADD;
        1: c = C_LW;
        2: c = C_LUI;
        3: c = C_SW;
        default: c = 12'($urandom_range(0, 4095));
      endcase
      drive($urandom_range(0, 7) != 0, c, $urandom(),
            rg($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
      step();
    end

`ifdef ID_EX_PERF_CNT_EN
    // drive the counter to saturation
    for (int i = 0; i < 65540; i++) begin
      drive(1'b1, C_ADD, 32'h600, rg(1, 2, 3), 1'b1, 1'b1);
      step();
    end
    chk("lit_cnt_sat", 32'(bubble_cnt), 32'hFFFF);
    drive(1'b1, C_ADD, 32'h604, rg(1, 2, 3), 1'b0, 1'b0);
    step();
    chk("lit_cnt_hold", 32'(bubble_cnt), 32'hFFFF);
`endif

    drive(1'b0, 12'd0, 32'd0, 15'd0, 1'b1, 1'b0);
    step();
    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
